// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the SRAM arbiter: state encoding, requester ids, data width.
package sram_arb_pkg;
    localparam int SRAM_DW = 8;

    localparam logic REQ_VGA = 1'b0;
    localparam logic REQ_CPU = 1'b1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_RD       = 3'd1;
    localparam logic [2:0] ST_WR_SETUP = 3'd2;
    localparam logic [2:0] ST_WR_PULSE = 3'd3;
    localparam logic [2:0] ST_WR_HOLD  = 3'd4;
    localparam logic [2:0] ST_TURN     = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        RD       = ST_RD,
        WR_SETUP = ST_WR_SETUP,
        WR_PULSE = ST_WR_PULSE,
        WR_HOLD  = ST_WR_HOLD,
        TURN     = ST_TURN
    } state_t;
endpackage

// File: rtl/sram_arbiter_if.sv
// Requester handshakes and SRAM pin bundle; slave = arbiter view, master = environment view.
interface sram_arbiter_if
    import sram_arb_pkg::*;
#(
    parameter int AW = 21
);
    logic               vga_req;
    logic [AW-1:0]      vga_addr;
    logic               vga_ack;
    logic [SRAM_DW-1:0] vga_rdata;

    logic               cpu_req;
    logic               cpu_we;
    logic [AW-1:0]      cpu_addr;
    logic [SRAM_DW-1:0] cpu_wdata;
    logic               cpu_ack;
    logic [SRAM_DW-1:0] cpu_rdata;

    logic [AW-1:0]      sram_addr;
    logic [SRAM_DW-1:0] sram_dout;
    logic               sram_doe;
    logic [SRAM_DW-1:0] sram_din;
    logic               sram_ce;
    logic               sram_oe;
    logic               sram_we;

    modport slave (
        input  vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_din,
        output vga_ack, vga_rdata, cpu_ack, cpu_rdata,
               sram_addr, sram_dout, sram_doe, sram_ce, sram_oe, sram_we
    );

    modport master (
        output vga_req, vga_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, sram_din,
        input  vga_ack, vga_rdata, cpu_ack, cpu_rdata,
               sram_addr, sram_dout, sram_doe, sram_ce, sram_oe, sram_we
    );
endinterface

// File: rtl/sram_arbiter_wait_ctr.sv
// Loadable down-counter that stops at zero; tc is high while the count is zero.
module sram_wait_ctr #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);
    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);
endmodule

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the external async SRAM; VGA priority with a CPU anti-starvation streak limit.
// Optional grant/wait statistics under SRAM_ARBITER_STATS_EN. Requests are level-held until ack.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int AW            = 21,
    parameter int RD_CYCLES     = 2,
    parameter int WR_CYCLES     = 2,
    parameter int MAX_VGA_BURST = 8
) (
    input  logic clk,
    input  logic reset,
    sram_arbiter_if.slave bus
`ifdef SRAM_ARBITER_STATS_EN
    ,
    output logic [31:0] stat_vga_grants,
    output logic [31:0] stat_cpu_grants,
    output logic [31:0] stat_cpu_wait
`endif
);
    localparam int CMAX = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(MAX_VGA_BURST + 1);
    localparam logic [SW-1:0] SMAX = SW'(MAX_VGA_BURST);

    state_t        state;
    logic          owner;
    logic [SW-1:0] streak;
    logic          grant_vga, grant_cpu;
    logic          ctr_load, ctr_tc;
    logic [CW-1:0] ctr_val;

    always_comb begin
        grant_vga = (state == IDLE) && bus.vga_req && (!bus.cpu_req || streak != SMAX);
        grant_cpu = (state == IDLE) && bus.cpu_req && !grant_vga;
        ctr_load  = grant_vga || grant_cpu || (state == WR_SETUP);
        ctr_val   = (state == WR_SETUP) ? CW'(WR_CYCLES - 1) : CW'(RD_CYCLES - 1);
    end

    sram_wait_ctr #(.W(CW)) u_wait_ctr (
        .clk      (clk),
        .reset    (reset),
        .load     (ctr_load),
        .load_val (ctr_val),
        .tc       (ctr_tc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            owner          <= REQ_VGA;
            streak         <= '0;
            bus.sram_addr  <= '0;
            bus.sram_dout  <= '0;
            bus.sram_doe   <= 1'b0;
            bus.sram_ce    <= 1'b1;
            bus.sram_oe    <= 1'b1;
            bus.sram_we    <= 1'b1;
            bus.vga_ack    <= 1'b0;
            bus.cpu_ack    <= 1'b0;
            bus.vga_rdata  <= '0;
            bus.cpu_rdata  <= '0;
        end else begin
            bus.vga_ack <= 1'b0;
            bus.cpu_ack <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_cpu || !bus.cpu_req) begin
                        streak <= '0;
                    end else if (grant_vga && streak != SMAX) begin
                        streak <= streak + 1'b1;
                    end
                    if (grant_vga) begin
                        owner         <= REQ_VGA;
                        bus.sram_addr <= bus.vga_addr;
                        bus.sram_ce   <= 1'b0;
                        bus.sram_oe   <= 1'b0;
                        state         <= RD;
                    end else if (grant_cpu) begin
                        owner         <= REQ_CPU;
                        bus.sram_addr <= bus.cpu_addr;
                        bus.sram_ce   <= 1'b0;
                        if (bus.cpu_we) begin
                            bus.sram_dout <= bus.cpu_wdata;
                            bus.sram_doe  <= 1'b1;
                            state         <= WR_SETUP;
                        end else begin
                            bus.sram_oe   <= 1'b0;
                            state         <= RD;
                        end
                    end
                end
                RD: begin
                    if (ctr_tc) begin
                        bus.sram_ce <= 1'b1;
                        bus.sram_oe <= 1'b1;
                        state       <= IDLE;
                        if (owner == REQ_VGA) begin
                            bus.vga_rdata <= bus.sram_din;
                            bus.vga_ack   <= 1'b1;
                        end else begin
                            bus.cpu_rdata <= bus.sram_din;
                            bus.cpu_ack   <= 1'b1;
                        end
                    end
                end
                WR_SETUP: begin
                    bus.sram_we <= 1'b0;
                    state       <= WR_PULSE;
                end
                WR_PULSE: begin
                    if (ctr_tc) begin
                        bus.sram_we <= 1'b1;
                        bus.cpu_ack <= 1'b1;
                        state       <= WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    // Release the data bus one cycle before IDLE so a following read never overlaps it.
                    bus.sram_ce  <= 1'b1;
                    bus.sram_doe <= 1'b0;
                    state        <= TURN;
                end
                TURN:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SRAM_ARBITER_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_vga_grants <= '0;
            stat_cpu_grants <= '0;
            stat_cpu_wait   <= '0;
        end else begin
            if (grant_vga) stat_vga_grants <= stat_vga_grants + 1'b1;
            if (grant_cpu) stat_cpu_grants <= stat_cpu_grants + 1'b1;
            if (bus.cpu_req && !(state != IDLE && owner == REQ_CPU)) begin
                stat_cpu_wait <= stat_cpu_wait + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, CPU read/write sequencing, VGA streaming, fairness, mid-access reset.
module tb_sram_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sram_arbiter_if #(.AW(21)) bus ();

`ifdef SRAM_ARBITER_STATS_EN
    logic [31:0] stat_vga_grants, stat_cpu_grants, stat_cpu_wait;
`endif

    sram_arbiter #(.AW(21), .RD_CYCLES(2), .WR_CYCLES(2), .MAX_VGA_BURST(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SRAM_ARBITER_STATS_EN
        ,
        .stat_vga_grants (stat_vga_grants),
        .stat_cpu_grants (stat_cpu_grants),
        .stat_cpu_wait   (stat_cpu_wait)
`endif
    );

    // Byte-wide async SRAM model; writes commit on the rising edge of we.
    logic [7:0] mem [0:(1<<21)-1];
    assign bus.sram_din = (!bus.sram_ce && !bus.sram_oe) ? mem[bus.sram_addr] : 8'h00;
    always @(posedge bus.sram_we) begin
        if (!reset && !bus.sram_ce && bus.sram_doe) mem[bus.sram_addr] = bus.sram_dout;
    end

    int contention = 0;
    always @(negedge clk) if (!bus.sram_oe && bus.sram_doe) contention++;

    int checks = 0;
    int passed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    logic        tr_ce [16];
    logic        tr_oe [16];
    logic        tr_we [16];
    logic        tr_doe[16];
    logic        tr_ack[16];
    logic [20:0] tr_addr[16];
    logic [7:0]  tr_dout[16];

    // Called at a negedge; the next posedge is the grant edge, trace index 1 is the cycle after it.
    task automatic run_cpu(input logic we, input logic [20:0] a, input logic [7:0] d);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        for (int c = 0; c < 16; c++) begin
            tr_ce[c] = 1'b1; tr_oe[c] = 1'b1; tr_we[c] = 1'b1; tr_doe[c] = 1'b0;
            tr_ack[c] = 1'b0; tr_addr[c] = '0; tr_dout[c] = '0;
        end
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            tr_ce[c] = bus.sram_ce; tr_oe[c] = bus.sram_oe; tr_we[c] = bus.sram_we;
            tr_doe[c] = bus.sram_doe; tr_ack[c] = bus.cpu_ack;
            tr_addr[c] = bus.sram_addr; tr_dout[c] = bus.sram_dout;
            if (bus.cpu_ack) bus.cpu_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    int n, cyc, last, we_low;
    logic [31:0] s_vg, s_cg, s_cw;

    initial begin
        bus.vga_req = 1'b0; bus.vga_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        for (int i = 0; i < 16; i++) mem[i] = 8'hC0 + 8'(i);
        mem[21'h00123] = 8'hA5;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ce",   {31'd0, bus.sram_ce},  32'd1);
        check("rst_oe",   {31'd0, bus.sram_oe},  32'd1);
        check("rst_we",   {31'd0, bus.sram_we},  32'd1);
        check("rst_doe",  {31'd0, bus.sram_doe}, 32'd0);
        check("rst_addr", {11'd0, bus.sram_addr}, 32'd0);
        check("rst_dout", {24'd0, bus.sram_dout}, 32'd0);
        check("rst_acks", {30'd0, bus.vga_ack, bus.cpu_ack}, 32'd0);
        check("rst_rdata", {16'd0, bus.vga_rdata, bus.cpu_rdata}, 32'd0);
`ifdef SRAM_ARBITER_STATS_EN
        check("rst_stats", stat_vga_grants | stat_cpu_grants | stat_cpu_wait, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        // CPU read of 0x00123
        run_cpu(1'b0, 21'h00123, 8'h00);
        check("rd_c1_ce_oe", {30'd0, tr_ce[1], tr_oe[1]}, 32'd0);
        check("rd_c2_ce_oe", {30'd0, tr_ce[2], tr_oe[2]}, 32'd0);
        check("rd_c1_addr", {11'd0, tr_addr[1]}, 32'h00123);
        check("rd_ack_c2", {31'd0, tr_ack[2]}, 32'd0);
        check("rd_ack_c3", {31'd0, tr_ack[3]}, 32'd1);
        check("rd_ack_c4", {31'd0, tr_ack[4]}, 32'd0);
        check("rd_c3_ce", {31'd0, tr_ce[3]}, 32'd1);
        check("rd_rdata", {24'd0, bus.cpu_rdata}, 32'hA5);
        we_low = 0;
        for (int c = 1; c < 12; c++) if (!tr_we[c] || tr_doe[c]) we_low++;
        check("rd_we_high", we_low, 32'd0);

        // CPU write 0x5A to 0x1FFFFF
        run_cpu(1'b1, 21'h1FFFFF, 8'h5A);
        check("wr_c1_setup", {28'd0, tr_ce[1], tr_we[1], tr_doe[1], tr_oe[1]}, 32'b0111);
        check("wr_c1_addr", {11'd0, tr_addr[1]}, 32'h1FFFFF);
        check("wr_c1_dout", {24'd0, tr_dout[1]}, 32'h5A);
        check("wr_c2_we", {31'd0, tr_we[2]}, 32'd0);
        check("wr_c3_we", {31'd0, tr_we[3]}, 32'd0);
        check("wr_c3_ack", {31'd0, tr_ack[3]}, 32'd0);
        check("wr_c4_hold", {28'd0, tr_ce[4], tr_we[4], tr_doe[4], tr_ack[4]}, 32'b0111);
        check("wr_c5_turn", {29'd0, tr_ce[5], tr_doe[5], tr_ack[5]}, 32'b100);
        check("wr_mem", {24'd0, mem[21'h1FFFFF]}, 32'h5A);
        check("no_contention", contention, 32'd0);

        // VGA streaming 0..15
        bus.vga_req = 1'b1; bus.vga_addr = '0;
        n = 0; cyc = 0; last = 0;
        while (n < 16 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (bus.vga_ack) begin
                check("vga_rdata", {24'd0, bus.vga_rdata}, 32'hC0 + 32'(n));
                if (n == 0) check("vga_first_lat", cyc, 32'd3);
                else check("vga_spacing", cyc - last, 32'd3);
                last = cyc;
                n++;
                if (n == 16) bus.vga_req = 1'b0;
                else bus.vga_addr = 21'(n);
            end
            check("vga_no_cpu_ack", {31'd0, bus.cpu_ack}, 32'd0);
        end
        check("vga_ack_count", n, 32'd16);
        repeat (4) @(negedge clk);

        // Fairness: both requesters held continuously
`ifdef SRAM_ARBITER_STATS_EN
        s_vg = stat_vga_grants; s_cg = stat_cpu_grants; s_cw = stat_cpu_wait;
`else
        s_vg = '0; s_cg = '0; s_cw = '0;
`endif
        bus.vga_addr = 21'd5;
        bus.cpu_we = 1'b0; bus.cpu_addr = 21'h00123;
        bus.vga_req = 1'b1; bus.cpu_req = 1'b1;
        n = 0; cyc = 0;
        while (n < 36 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (bus.vga_ack || bus.cpu_ack) begin
                check("fair_order", {30'd0, bus.vga_ack, bus.cpu_ack}, (n % 9 == 8) ? 32'b01 : 32'b10);
                if (bus.cpu_ack) check("fair_cpu_rdata", {24'd0, bus.cpu_rdata}, 32'hA5);
                else check("fair_vga_rdata", {24'd0, bus.vga_rdata}, 32'hC5);
                n++;
            end
        end
        check("fair_ack_count", n, 32'd36);
`ifdef SRAM_ARBITER_STATS_EN
        check("stat_vga_delta", stat_vga_grants - s_vg, 32'd32);
        check("stat_cpu_delta", stat_cpu_grants - s_cg, 32'd4);
        check("stat_wait_nonzero", {31'd0, (stat_cpu_wait - s_cw) != 0}, 32'd1);
`endif
        bus.vga_req = 1'b0; bus.cpu_req = 1'b0;
        repeat (8) @(negedge clk);

        // Mid-access reset during second WR_PULSE cycle
        mem[21'h00200] = 8'h11;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 21'h00200; bus.cpu_wdata = 8'h77;
        repeat (3) @(negedge clk);
        check("mid_we_low", {31'd0, bus.sram_we}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_rst_strobes", {29'd0, bus.sram_ce, bus.sram_we, bus.sram_doe}, 32'b110);
        check("mid_rst_ack", {31'd0, bus.cpu_ack}, 32'd0);
        @(negedge clk);
        check("mid_rst_ack_held", {31'd0, bus.cpu_ack}, 32'd0);
        check("mid_mem_untouched", {24'd0, mem[21'h00200]}, 32'h11);
        reset = 1'b0;
        run_cpu(1'b1, 21'h00200, 8'h77);
        check("mid_regrant_ack", {31'd0, tr_ack[4]}, 32'd1);
        check("mid_regrant_mem", {24'd0, mem[21'h00200]}, 32'h77);
        check("final_contention", contention, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
